// File: rtl/kd_level_stage.sv
// rtl/kd_level_stage.sv - one pipelined KD-tree level: per-node split table, median compare, child index out
module kd_level_stage #(
    parameter int DATA_WIDTH    = 55,
    parameter int STORAGE_WIDTH = 22,
    parameter int COMP_WIDTH    = 11,
    parameter int NUM_COMP      = 5,
    parameter int LEVEL         = 2,
    parameter int IDX_W         = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wen,
    input  logic [IDX_W-1:0]         waddr,
    input  logic [STORAGE_WIDTH-1:0] wdata,
    input  logic                     valid_in,
    output logic                     ready_out,
    input  logic [IDX_W-1:0]         node_in,
    input  logic [DATA_WIDTH-1:0]    patch_in,
    output logic                     valid_out,
    input  logic                     ready_in,
    output logic [IDX_W:0]           node_out,
    output logic [DATA_WIDTH-1:0]    patch_out,
    output logic                     go_left,
    output logic                     go_right,
    output logic                     cfg_err
);
    localparam int N_NODES = 1 << LEVEL;
    localparam int CIDX_W  = STORAGE_WIDTH - COMP_WIDTH;

    logic [STORAGE_WIDTH-1:0] r_table [N_NODES];
    logic                     r_valid_out;
    logic [IDX_W:0]           r_node_out;
    logic [DATA_WIDTH-1:0]    r_patch_out;
    logic                     r_go_left;
    logic                     r_go_right;
    logic                     r_cfg_err;

    logic [IDX_W-1:0]         w_node;
    logic [IDX_W-1:0]         w_waddr;
    logic [STORAGE_WIDTH-1:0] w_entry;
    logic [CIDX_W-1:0]        w_comp;
    logic [COMP_WIDTH-1:0]    w_med;
    logic [COMP_WIDTH-1:0]    w_c;
    logic                     w_bad;
    logic                     w_go_right;
    logic                     w_xfer_in;

    // The root level has a single node, so its index inputs are forced to zero.
    assign w_node  = (LEVEL == 0) ? '0 : node_in;
    assign w_waddr = (LEVEL == 0) ? '0 : waddr;
    assign w_entry = r_table[w_node];
    assign w_comp  = w_entry[STORAGE_WIDTH-1:COMP_WIDTH];
    assign w_med   = w_entry[COMP_WIDTH-1:0];

    always_comb begin
        w_c   = '0;
        w_bad = 1'b1;
        for (int i = 0; i < NUM_COMP; i++) begin
            if (w_comp == CIDX_W'(i)) begin
                w_c   = patch_in[i*COMP_WIDTH +: COMP_WIDTH];
                w_bad = 1'b0;
            end
        end
    end

    assign w_go_right = w_bad | (w_c >= w_med);
    assign ready_out  = ~r_valid_out | ready_in;
    assign w_xfer_in  = valid_in & ready_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < N_NODES; n++) begin
                r_table[n] <= '0;
            end
            r_valid_out <= 1'b0;
            r_node_out  <= '0;
            r_patch_out <= '0;
            r_go_left   <= 1'b0;
            r_go_right  <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            // Table read above sees the pre-write entry, so a colliding write applies next cycle.
            if (wen) begin
                r_table[w_waddr] <= wdata;
            end
            if (w_xfer_in) begin
                r_valid_out <= 1'b1;
                r_patch_out <= patch_in;
                r_node_out  <= {w_node, w_go_right};
                r_go_right  <= w_go_right;
                r_go_left   <= ~w_go_right;
                if (w_bad) begin
                    r_cfg_err <= 1'b1;
                end
            end else if (ready_in) begin
                r_valid_out <= 1'b0;
                r_go_right  <= 1'b0;
                r_go_left   <= 1'b0;
            end
        end
    end

    assign valid_out = r_valid_out;
    assign node_out  = r_node_out;
    assign patch_out = r_patch_out;
    assign go_left   = r_go_left;
    assign go_right  = r_go_right;
    assign cfg_err   = r_cfg_err;
endmodule

// File: tb/tb_kd_level_stage.sv
// tb/tb_kd_level_stage.sv - directed self-checking bench for kd_level_stage
module tb_kd_level_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        wen;
    logic [1:0]  waddr;
    logic [21:0] wdata;
    logic        valid_in;
    logic        ready_out;
    logic [1:0]  node_in;
    logic [54:0] patch_in;
    logic        valid_out;
    logic        ready_in;
    logic [2:0]  node_out;
    logic [54:0] patch_out;
    logic        go_left;
    logic        go_right;
    logic        cfg_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    kd_level_stage dut (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
        .valid_in(valid_in), .ready_out(ready_out), .node_in(node_in), .patch_in(patch_in),
        .valid_out(valid_out), .ready_in(ready_in), .node_out(node_out), .patch_out(patch_out),
        .go_left(go_left), .go_right(go_right), .cfg_err(cfg_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [54:0] mkp(input logic [10:0] c0, c1, c2, c3, c4);
        return {c4, c3, c2, c1, c0};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    logic [54:0] held_patch;
    logic [54:0] stream [8];
    logic [7:0]  stream_right;

    initial begin
        rst_n = 1'b0; wen = 1'b0; waddr = '0; wdata = '0; valid_in = 1'b0;
        node_in = '0; patch_in = '0; ready_in = 1'b1;
        tick();
        #1;
        check("rst_valid_out", valid_out, 0);
        check("rst_go_left", go_left, 0);
        check("rst_go_right", go_right, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_ready_out", ready_out, 1);
        rst_n = 1'b1;
        tick();

        // reset table: median 0, comp 0 -> right
        valid_in = 1'b1; node_in = 2'd0; patch_in = mkp(11'd5, 11'd6, 11'd7, 11'd8, 11'd9);
        tick();
        check("t1_go_right", go_right, 1);
        check("t1_node_out", node_out, 3'b001);
        check("t1_patch_out", patch_out, mkp(11'd5, 11'd6, 11'd7, 11'd8, 11'd9));

        // left / right on node 2, comp 1 median 3
        valid_in = 1'b0; wen = 1'b1; waddr = 2'd2; wdata = {11'd1, 11'd3};
        tick();
        wen = 1'b0; valid_in = 1'b1; node_in = 2'd2; patch_in = mkp(11'd9, 11'd2, 11'd9, 11'd9, 11'd9);
        tick();
        check("t2_left_node", node_out, 3'b100);
        check("t2_left_gl", go_left, 1);
        check("t2_left_gr", go_right, 0);
        patch_in = mkp(11'd0, 11'd3, 11'd0, 11'd0, 11'd0);
        tick();
        check("t2_eq_node", node_out, 3'b101);
        check("t2_eq_gr", go_right, 1);
        check("t2_eq_gl", go_left, 0);
        held_patch = mkp(11'd0, 11'd3, 11'd0, 11'd0, 11'd0);

        // backpressure: hold 4 cycles with stream[0] offered
        for (int k = 0; k < 8; k++) stream[k] = mkp(11'(k + 20), 11'(k), 11'd0, 11'd0, 11'(k));
        stream_right = 8'b1111_1000;
        ready_in = 1'b0; node_in = 2'd2; patch_in = stream[0];
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t3_hold_ready_out", ready_out, 0);
            tick();
            check("t3_hold_valid", valid_out, 1);
            check("t3_hold_patch", patch_out, held_patch);
            check("t3_hold_node", node_out, 3'b101);
        end
        ready_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("t3_stream_valid", valid_out, 1);
            check("t3_stream_patch", patch_out, stream[k]);
            check("t3_stream_node", node_out, {2'd2, stream_right[k]});
            if (k < 7) patch_in = stream[k+1];
            else valid_in = 1'b0;
        end
        tick();
        check("t3_drain_valid", valid_out, 0);
        check("t3_drain_gr", go_right, 0);
        check("t3_drain_gl", go_left, 0);
        check("t3_drain_keep", patch_out, stream[7]);

        // collision on node 1
        wen = 1'b1; waddr = 2'd1; wdata = {11'd0, 11'd10};
        tick();
        wdata = {11'd0, 11'd100}; valid_in = 1'b1; node_in = 2'd1;
        patch_in = mkp(11'd50, 11'd0, 11'd0, 11'd0, 11'd0);
        tick();
        wen = 1'b0;
        check("t4_old_node", node_out, 3'b011);
        check("t4_old_gr", go_right, 1);
        tick();
        check("t4_new_node", node_out, 3'b010);
        check("t4_new_gl", go_left, 1);

        // bad component index on node 3
        valid_in = 1'b0; wen = 1'b1; waddr = 2'd3; wdata = {11'd7, 11'd500};
        tick();
        wen = 1'b0;
        check("t5_pre_err", cfg_err, 0);
        valid_in = 1'b1; node_in = 2'd3; patch_in = '0;
        tick();
        valid_in = 1'b0;
        check("t5_gr", go_right, 1);
        check("t5_node", node_out, 3'b111);
        check("t5_err", cfg_err, 1);
        tick(); tick();
        check("t5_err_sticky", cfg_err, 1);

        // async reset while holding
        ready_in = 1'b0; valid_in = 1'b1; node_in = 2'd2; patch_in = mkp(11'd1, 11'd9, 11'd1, 11'd1, 11'd1);
        tick();
        valid_in = 1'b0;
        check("t6_valid_before", valid_out, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid_async", valid_out, 0);
        check("t6_err_cleared", cfg_err, 0);
        check("t6_gr_cleared", go_right, 0);
        check("t6_patch_cleared", patch_out, 0);
        tick();
        rst_n = 1'b1; ready_in = 1'b1;
        tick();
        valid_in = 1'b1; node_in = 2'd3; patch_in = '0;
        tick();
        valid_in = 1'b0;
        check("t6_tbl_reset_node", node_out, 3'b111);
        check("t6_tbl_reset_err", cfg_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
